// File: rtl/e203_ifu_bht_pkg.sv
// e203_ifu_bht_pkg: shared sizes, counter encodings and FSM states for the branch history table
package e203_ifu_bht_pkg;
  localparam int BHT_ENTRIES = 64;
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} cnt_e;
  localparam logic [1:0] CNT_INIT = WNT;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/e203_bht_satcnt.sv
// e203_bht_satcnt: 2-bit saturating increment/decrement
module e203_bht_satcnt
  import e203_ifu_bht_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] nxt
);
  assign nxt = inc ? ((cnt == ST) ? cnt : cnt + 2'd1) : ((cnt == SNT) ? cnt : cnt - 2'd1);
endmodule

// File: rtl/e203_ifu_bht.sv
// e203_ifu_bht: 2-bit counter branch history table with init sweep, registered update stage and perf counters
module e203_ifu_bht
  import e203_ifu_bht_pkg::*;
#(
  parameter int PC_SIZE = 32,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bht_clr,
  input  logic              ifu_lkup_vld,
  input  logic              ifu_lkup_bxx,
  input  logic [PC_SIZE-1:0] ifu_lkup_pc,
  output logic              bht_prdt_vld,
  output logic              bht_prdt_taken,
  input  logic              bht_wb_vld,
  input  logic              bht_wb_mis,
  input  logic              bht_wb_prdt,
  input  logic              bht_wb_rslv,
  input  logic [PC_SIZE-1:0] bht_wb_pc,
  output logic              bht_ready,
  output logic [PERF_W-1:0] perf_lkup_cnt,
  output logic [PERF_W-1:0] perf_mis_cnt
);
  state_e           state;
  logic [IDX_W-1:0] sweep_idx, u_idx, lk_idx;
  logic             u_vld, u_rslv, u_mis, run, u_wr;
  logic [1:0]       tbl [BHT_ENTRIES];
  logic [1:0]       u_cur, u_new, lk_cnt;
  logic             unused_bits;
  assign run = state == RUN;
  assign lk_idx = ifu_lkup_pc[IDX_W:1];
  assign u_cur = tbl[u_idx];
  // a clear in the same cycle discards the pending update along with the table
  assign u_wr = run & u_vld & ~bht_clr;
  assign lk_cnt = (u_vld && u_idx == lk_idx) ? u_new : tbl[lk_idx];
  assign bht_ready = run;
  assign bht_prdt_vld = ifu_lkup_vld & ifu_lkup_bxx & run;
  assign bht_prdt_taken = bht_prdt_vld & lk_cnt[1];
  assign unused_bits = ^{ifu_lkup_pc[PC_SIZE-1:IDX_W+1], ifu_lkup_pc[0],
                         bht_wb_pc[PC_SIZE-1:IDX_W+1], bht_wb_pc[0], bht_wb_prdt};

  e203_bht_satcnt u_sat (.cnt(u_cur), .inc(u_rslv), .nxt(u_new));

  // single write port: init sweep owns it in INIT, the update stage in RUN
  always_ff @(posedge clk) begin
    if (!run || u_wr) tbl[run ? u_idx : sweep_idx] <= run ? u_new : CNT_INIT;
  end

  // update-stage payload, only meaningful while u_vld is set
  always_ff @(posedge clk) begin
    if (bht_wb_vld) {u_idx, u_rslv, u_mis} <= {bht_wb_pc[IDX_W:1], bht_wb_rslv, bht_wb_mis};
  end

  // FSM, update-stage valid and saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      sweep_idx <= '0;
      u_vld <= 1'b0;
      perf_lkup_cnt <= '0;
      perf_mis_cnt <= '0;
    end else begin
      if (bht_clr) begin
        state <= INIT;
        sweep_idx <= '0;
      end else if (!run) begin
        sweep_idx <= sweep_idx + IDX_W'(1);
        if (&sweep_idx) state <= RUN;
      end
      u_vld <= run & bht_wb_vld & ~bht_clr;
      if (bht_prdt_vld && !(&perf_lkup_cnt)) perf_lkup_cnt <= perf_lkup_cnt + PERF_W'(1);
      if (u_wr && u_mis && !(&perf_mis_cnt)) perf_mis_cnt <= perf_mis_cnt + PERF_W'(1);
    end
  end

  a_mis_consistent: assert property (@(posedge clk) disable iff (rst)
    bht_wb_vld |-> (bht_wb_mis == (bht_wb_prdt ^ bht_wb_rslv)));
endmodule

// File: tb/tb_e203_ifu_bht.sv
// tb_e203_ifu_bht: directed vector and sequence checks of the branch history table
module tb_e203_ifu_bht;
  logic        clk = 1'b0, rst, bht_clr;
  logic        lk_vld, lk_bxx, wb_vld, wb_mis, wb_prdt, wb_rslv;
  logic [31:0] lk_pc, wb_pc;
  logic        prdt_vld, prdt_taken, ready;
  logic [31:0] perf_lk, perf_mis;
  logic        s_prdt_vld, s_prdt_taken, s_ready;
  logic [3:0]  s_perf_lk, s_perf_mis;
  int          n_chk = 0, n_fail = 0;

  localparam logic [31:0] A = 32'h8000_0010, B = 32'h8000_0020, F = 32'h8000_0040;
  localparam logic [31:0] C = 32'h8000_0002, D = 32'h8000_0082, E = 32'h8000_0004;

  typedef struct {
    bit          wv;
    bit          wr;
    bit          wm;
    logic [31:0] wpc;
    logic [31:0] lpc;
    bit          tk;
  } vec_t;
  vec_t v[18];

  always #5 clk = ~clk;

  e203_ifu_bht dut (
    .clk(clk), .rst(rst), .bht_clr(bht_clr),
    .ifu_lkup_vld(lk_vld), .ifu_lkup_bxx(lk_bxx), .ifu_lkup_pc(lk_pc),
    .bht_prdt_vld(prdt_vld), .bht_prdt_taken(prdt_taken),
    .bht_wb_vld(wb_vld), .bht_wb_mis(wb_mis), .bht_wb_prdt(wb_prdt),
    .bht_wb_rslv(wb_rslv), .bht_wb_pc(wb_pc),
    .bht_ready(ready), .perf_lkup_cnt(perf_lk), .perf_mis_cnt(perf_mis)
  );

  e203_ifu_bht #(.PERF_W(4)) dut4 (
    .clk(clk), .rst(rst), .bht_clr(bht_clr),
    .ifu_lkup_vld(lk_vld), .ifu_lkup_bxx(lk_bxx), .ifu_lkup_pc(lk_pc),
    .bht_prdt_vld(s_prdt_vld), .bht_prdt_taken(s_prdt_taken),
    .bht_wb_vld(wb_vld), .bht_wb_mis(wb_mis), .bht_wb_prdt(wb_prdt),
    .bht_wb_rslv(wb_rslv), .bht_wb_pc(wb_pc),
    .bht_ready(s_ready), .perf_lkup_cnt(s_perf_lk), .perf_mis_cnt(s_perf_mis)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit lv, input bit lb, input logic [31:0] lpc,
                     input bit wv, input bit wr, input bit wm, input logic [31:0] wpc);
    lk_vld = lv; lk_bxx = lb; lk_pc = lpc;
    wb_vld = wv; wb_rslv = wr; wb_mis = wm; wb_prdt = wr ^ wm; wb_pc = wpc;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{1, 1, 0, A, A, 0};
    v[1]  = '{1, 1, 0, A, A, 1};
    v[2]  = '{1, 1, 0, A, A, 1};
    v[3]  = '{0, 0, 0, A, A, 1};
    v[4]  = '{1, 0, 0, A, A, 1};
    v[5]  = '{1, 0, 0, A, A, 1};
    v[6]  = '{0, 0, 0, A, A, 0};
    v[7]  = '{0, 0, 0, A, A, 0};
    v[8]  = '{1, 1, 0, B, A, 0};
    v[9]  = '{0, 0, 0, B, F, 0};
    v[10] = '{0, 0, 0, B, B, 1};
    v[11] = '{1, 1, 0, C, E, 0};
    v[12] = '{1, 1, 0, D, E, 0};
    v[13] = '{0, 0, 0, C, C, 1};
    v[14] = '{1, 0, 0, C, E, 0};
    v[15] = '{1, 0, 0, C, D, 1};
    v[16] = '{0, 0, 0, C, D, 0};
    v[17] = '{0, 0, 0, C, C, 0};

    rst = 1'b1; bht_clr = 1'b0;
    drv(1, 1, A, 0, 0, 0, A);
    step();
    chk("rst_ready", ready, 0);
    chk("rst_prdt_vld", prdt_vld, 0);
    chk("rst_taken", prdt_taken, 0);
    chk("rst_perf_lk", perf_lk, 0);
    chk("rst_perf_mis", perf_mis, 0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("sweep_ready", ready, 0);
      if (i == 10) chk("sweep_prdt_vld", prdt_vld, 0);
      step();
    end
    chk("init_done_ready", ready, 1);
    drv(1, 1, 32'h8000_0000, 0, 0, 0, A);
    #1;
    chk("init_lk0_vld", prdt_vld, 1);
    chk("init_lk0_taken", prdt_taken, 0);
    drv(1, 1, 32'h8000_007E, 0, 0, 0, A);
    #1;
    chk("init_lk63_taken", prdt_taken, 0);

    for (int i = 0; i < 18; i++) begin
      drv(1, 1, v[i].lpc, v[i].wv, v[i].wr, v[i].wm, v[i].wpc);
      #1;
      chk($sformatf("vec%0d_vld", i), prdt_vld, 1);
      chk($sformatf("vec%0d_taken", i), prdt_taken, v[i].tk);
      step();
    end

    drv(0, 0, A, 0, 0, 0, A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_perf_lk", perf_lk, 0);
    chk("rst2_perf_mis", perf_mis, 0);
    chk("rst2_s_perf_lk", s_perf_lk, 0);
    for (int i = 0; i < 64; i++) step();
    chk("rst2_ready", ready, 1);
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, A, 1, 1, (i == 0 || i == 2), A);
      step();
    end
    drv(1, 0, A, 0, 0, 0, A);
    #1;
    chk("nonbxx_prdt_vld", prdt_vld, 0);
    step();
    step();
    chk("perf_lk5", perf_lk, 5);
    chk("perf_mis2", perf_mis, 2);
    chk("s_perf_lk5", s_perf_lk, 5);
    drv(1, 1, A, 0, 0, 0, A);
    #1;
    chk("trained_taken", prdt_taken, 1);
    step();

    drv(0, 0, A, 0, 0, 0, A);
    bht_clr = 1'b1;
    step();
    bht_clr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 20) drv(1, 1, A, 1, 1, 1, A);
      else drv(0, 0, A, 0, 0, 0, A);
      #1;
      chk("clr_sweep_ready", ready, 0);
      if (i == 20) chk("clr_sweep_prdt_vld", prdt_vld, 0);
      step();
    end
    drv(0, 0, A, 0, 0, 0, A);
    #1;
    chk("clr_done_ready", ready, 1);
    chk("clr_keep_perf_lk", perf_lk, 6);
    chk("clr_keep_perf_mis", perf_mis, 2);
    drv(1, 1, A, 0, 0, 0, A);
    #1;
    chk("clr_reinit_taken", prdt_taken, 0);
    step();
    for (int i = 0; i < 13; i++) begin
      drv(1, 1, 32'h8000_0000, 0, 0, 0, A);
      step();
    end
    drv(0, 0, A, 0, 0, 0, A);
    #1;
    chk("perf_lk20", perf_lk, 20);
    chk("s_perf_lk_sat", s_perf_lk, 15);
    drv(1, 1, A, 0, 0, 0, A);
    step();
    chk("s_perf_lk_hold", s_perf_lk, 15);

    drv(0, 0, A, 1, 1, 1, A);
    step();
    rst = 1'b1;
    drv(0, 0, A, 0, 0, 0, A);
    step();
    rst = 1'b0;
    chk("rst_mid_ready", ready, 0);
    chk("rst_mid_perf_mis", perf_mis, 0);
    chk("rst_mid_perf_lk", perf_lk, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
